addsub_issue_ctrl: RTL and testbench

//  Sequencing front/back end for the combinational 16-bit prefix adder/subtractor (a,b,cin,sel -> o).

---
 rtl/addsub_issue_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_addsub_issue_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl
//   Sequencer that sits in front of, and behind, a combinational WIDTH-bit
//   adder/subtractor (a, b, cin, sel -> o). A request is accepted over a
//   valid/ready handshake. The request's operands are presented to the adder
//   for one cycle. The sum and its status flags are then captured and held on
//   a valid/ready result port until the result is consumed. An internal
//   accumulator tracks the last sum so that ACC_ADD and ACC_SUB chains do not
//   need the running value from the host.
//
//   State table
//     state | meaning
//     IDLE  | ready for a request; operand regs load on accept
//     ISSUE | adder is driven from the operand regs; sum captured at end of cycle
//     HOLD  | result presented; waits for o_res_valid & i_res_ready
//
// Ports
//   clk, rst_n                  clock and asynchronous active-low reset
//   i_in_valid / o_in_ready     request handshake
//   i_in_op                     00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB
//   i_in_a, i_in_b, i_in_cin    operands (i_in_a is ignored for ACC ops; i_in_cin is ignored for SUB)
//   i_acc_clr                   synchronous accumulator clear
//   o_add_a/b/cin/sel, i_add_o  interface to the external adder
//   o_res_valid / i_res_ready   result handshake
//   o_res_data, o_res_c/v/n/z   captured sum and status flags
module addsub_issue_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [1:0]       i_in_op,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic             i_in_cin,
    input  logic             i_acc_clr,
    output logic [WIDTH-1:0] o_add_a,
    output logic [WIDTH-1:0] o_add_b,
    output logic             o_add_cin,
    output logic             o_add_sel,
    input  logic [WIDTH-1:0] i_add_o,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_data,
    output logic             o_res_c,
    output logic             o_res_v,
    output logic             o_res_n,
    output logic             o_res_z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_in_ready;
    logic w_res_valid;
    logic w_accept;
    logic w_capture;
    logic w_consume;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_sel;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH-1:0] r_res_data;
    logic             r_res_c;
    logic             r_res_v;
    logic             r_res_n;
    logic             r_res_z;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c;
    logic             w_v;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_in_valid)  w_state_nxt = ISSUE;
            ISSUE:                    w_state_nxt = HOLD;
            HOLD:    if (i_res_ready) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // State decode
    always_comb begin
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            ISSUE:   w_capture   = 1'b1;
            HOLD:    w_res_valid = 1'b1;
            default: w_in_ready  = 1'b0;
        endcase
    end

    assign w_accept  = w_in_ready & i_in_valid;
    assign w_consume = w_res_valid & i_res_ready;

    // Operand registers drive the adder directly. They change only on accept,
    // so the adder inputs keep their last values outside ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
            r_sel <= 1'b0;
        end else if (w_accept) begin
            r_a   <= i_in_op[1] ? r_acc : i_in_a;
            r_b   <= i_in_b;
            r_sel <= i_in_op[0];
            // A subtract is A + ~B + 1, so the carry-in is forced high for SUB.
            r_cin <= i_in_op[0] ? 1'b1 : i_in_cin;
        end
    end

    // The flags are derived from the operand MSBs and the sum MSB. The
    // adder's carry-out is not available, so it is reconstructed here.
    assign w_b_eff = r_sel ? ~r_b : r_b;
    assign w_c     = (r_a[WIDTH-1] & w_b_eff[WIDTH-1]) |
                     ((r_a[WIDTH-1] ^ w_b_eff[WIDTH-1]) & ~i_add_o[WIDTH-1]);
    assign w_v     = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) &
                     (i_add_o[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_data <= '0;
            r_res_c    <= 1'b0;
            r_res_v    <= 1'b0;
            r_res_n    <= 1'b0;
            r_res_z    <= 1'b0;
        end else if (w_capture) begin
            r_res_data <= i_add_o;
            r_res_c    <= w_c;
            r_res_v    <= w_v;
            r_res_n    <= i_add_o[WIDTH-1];
            r_res_z    <= (i_add_o == '0);
        end
    end

    // A clear overrides the capture. The result port still shows the sum,
    // but the accumulator starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_acc_clr) begin
            r_acc <= '0;
        end else if (w_capture) begin
            r_acc <= i_add_o;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_res_valid = w_res_valid;
    assign o_add_a     = r_a;
    assign o_add_b     = r_b;
    assign o_add_cin   = r_cin;
    assign o_add_sel   = r_sel;
    assign o_res_data  = r_res_data;
    assign o_res_c     = r_res_c;
    assign o_res_v     = r_res_v;
    assign o_res_n     = r_res_n;
    assign o_res_z     = r_res_z;

    // The consume handshake is implied by the HOLD -> IDLE transition.
    logic w_unused;
    assign w_unused = w_consume;

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// Directed bench for addsub_issue_ctrl. A behavioural adder closes the loop
// on the add_* / add_o interface. Every expected value below was worked out
// by hand.
module tb_addsub_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        acc_clr;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic        add_sel;
    logic [15:0] add_o;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_c;
    logic        res_v;
    logic        res_n;
    logic        res_z;

    int n_checks = 0;
    int n_fail   = 0;

    addsub_issue_ctrl #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_op    (in_op),
        .i_in_a     (in_a),
        .i_in_b     (in_b),
        .i_in_cin   (in_cin),
        .i_acc_clr  (acc_clr),
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .o_add_cin  (add_cin),
        .o_add_sel  (add_sel),
        .i_add_o    (add_o),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_res_data (res_data),
        .o_res_c    (res_c),
        .o_res_v    (res_v),
        .o_res_n    (res_n),
        .o_res_z    (res_z)
    );

    // External prefix adder stand-in
    assign add_o = add_a + (add_sel ? ~add_b : add_b) + {15'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and check the ISSUE-cycle adder drive and the result.
    // clr_issue raises acc_clr during the ISSUE cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic clr_issue,
                          input logic [15:0] ea, input logic esel, input logic ecin,
                          input logic [15:0] ed, input logic ec, input logic ev,
                          input logic en, input logic ez, input logic consume);
        @(negedge clk);
        check_val({tag, ".idle_rdy"}, in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr  = clr_issue;
        @(negedge clk);
        check_val({tag, ".iss_rdy"}, in_ready, 0);
        check_val({tag, ".iss_rv"}, res_valid, 0);
        check_val({tag, ".add_a"}, add_a, ea);
        check_val({tag, ".add_b"}, add_b, b);
        check_val({tag, ".add_sel"}, add_sel, esel);
        check_val({tag, ".add_cin"}, add_cin, ecin);
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        @(negedge clk);
        check_val({tag, ".res_valid"}, res_valid, 1);
        check_val({tag, ".res_data"}, res_data, ed);
        check_val({tag, ".flags_cvnz"}, {res_c, res_v, res_n, res_z}, {ec, ev, en, ez});
        if (consume) begin
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        in_cin = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;
        #12;
        check_val("rst.in_ready", in_ready, 1);
        check_val("rst.res_valid", res_valid, 0);
        check_val("rst.res_data", res_data, 0);
        check_val("rst.flags", {res_c, res_v, res_n, res_z}, 0);
        check_val("rst.add", {add_a, add_b, add_cin, add_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // res_ready while no result is pending has no effect
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val("idle.rv", res_valid, 0);

        //        tag      op     a        b        cin clr ea       sel cin data     c  v  n  z  cons
        run_op("add_aa", 2'b00, 16'hAAAA, 16'h5555, 0, 0, 16'hAAAA, 0, 0, 16'hFFFF, 0, 0, 1, 0, 1);
        run_op("sub_aa", 2'b01, 16'hAAAA, 16'h5555, 0, 0, 16'hAAAA, 1, 1, 16'h5555, 1, 1, 0, 0, 1);
        run_op("sub_neg", 2'b01, 16'h002E, 16'h004F, 0, 0, 16'h002E, 1, 1, 16'hFFDF, 0, 0, 1, 0, 1);
        run_op("add_ovf", 2'b00, 16'h7FFF, 16'h0001, 0, 0, 16'h7FFF, 0, 0, 16'h8000, 0, 1, 1, 0, 1);
        run_op("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 0, 0, 16'hFFFF, 0, 0, 16'h0000, 1, 0, 0, 1, 1);
        run_op("add_cin", 2'b00, 16'h1234, 16'h0001, 1, 0, 16'h1234, 0, 1, 16'h1236, 0, 0, 0, 0, 1);
        run_op("sub_cin", 2'b01, 16'h0010, 16'h0003, 0, 0, 16'h0010, 1, 1, 16'h000D, 1, 0, 0, 0, 1);

        // The accumulator holds 0x000D. Clear it, then chain ops.
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        run_op("acc1", 2'b10, 16'hDEAD, 16'h0005, 0, 0, 16'h0000, 0, 0, 16'h0005, 0, 0, 0, 0, 1);
        run_op("acc2", 2'b10, 16'hDEAD, 16'h0005, 0, 0, 16'h0005, 0, 0, 16'h000A, 0, 0, 0, 0, 1);
        run_op("acc3", 2'b10, 16'hDEAD, 16'h0005, 0, 0, 16'h000A, 0, 0, 16'h000F, 0, 0, 0, 0, 1);
        run_op("accsub", 2'b11, 16'hDEAD, 16'h000F, 0, 0, 16'h000F, 1, 1, 16'h0000, 1, 0, 0, 1, 1);

        // A clear during ISSUE: the result still shows the sum, but the accumulator ends at zero.
        run_op("clr_iss", 2'b10, 16'h0000, 16'h0007, 0, 1, 16'h0000, 0, 0, 16'h0007, 0, 0, 0, 0, 1);
        run_op("after_clr", 2'b10, 16'h0000, 16'h0003, 0, 0, 16'h0000, 0, 0, 16'h0003, 0, 0, 0, 0, 1);

        // Backpressure: hold the result with new requests presented
        run_op("bp", 2'b00, 16'h0100, 16'h0023, 0, 0, 16'h0100, 0, 0, 16'h0123, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = 2'b00;
            in_a     = 16'h0001;
            in_b     = 16'h0001;
            check_val("bp.rv", res_valid, 1);
            check_val("bp.data", res_data, 16'h0123);
            check_val("bp.in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check_val("bp.rel_rdy", in_ready, 1);
        check_val("bp.rel_rv", res_valid, 0);
        @(negedge clk);
        check_val("bp.no_ghost", res_valid, 0);

        // Asynchronous reset in the middle of ISSUE (the accumulator holds 0x0123)
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_b     = 16'h0009;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst.in_ready", in_ready, 1);
        check_val("arst.res_valid", res_valid, 0);
        check_val("arst.add_a", add_a, 0);
        check_val("arst.res_data", res_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("arst_acc", 2'b10, 16'hBEEF, 16'h0004, 0, 0, 16'h0000, 0, 0, 16'h0004, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
